// File: rtl/exc_ctrl_nested_if.sv
// exc_ctrl_nested_if: CPU-side request/redirect bundle for the exception controller
interface exc_ctrl_nested_if #(parameter int NUM_SRC = 3);
  localparam int DW = $clog2(NUM_SRC + 1);
  logic [NUM_SRC-1:0] exp_src;
  logic               exp_block;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [31:0]        pc_in;
  logic               is_eret;
  logic               has_exp;
  logic               ret_valid;
  logic [31:0]        target_pc;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] mask;
  logic [DW-1:0]      depth;
  modport master (
    output exp_src, exp_block, mask_we, mask_wdata, pc_in, is_eret,
    input  has_exp, ret_valid, target_pc, pending, in_service, mask, depth
  );
  modport slave (
    input  exp_src, exp_block, mask_we, mask_wdata, pc_in, is_eret,
    output has_exp, ret_valid, target_pc, pending, in_service, mask, depth
  );
endinterface

// File: rtl/exc_ctrl_nested.sv
// exc_ctrl_nested: masked fixed-priority exception controller with EPC stack; EXC_NESTING_EN enables priority nesting
module exc_ctrl_nested #(
  parameter int          NUM_SRC    = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0080
) (
  input logic clk,
  input logic rst,
  exc_ctrl_nested_if.slave bus
);
  localparam int DW = $clog2(NUM_SRC + 1);
  localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
`ifdef EXC_NESTING_EN
  localparam int SD = NUM_SRC;
`else
  localparam int SD = 1;
`endif
  localparam int SW = SD > 1 ? $clog2(SD) : 1;
  logic [NUM_SRC-1:0] prev, pending, in_service, mask, rise, cand_oh, cur_oh;
  logic [DW-1:0]      depth;
  logic [31:0]        stk [SD];
  logic [IW-1:0]      cand_i, cur_i;
  logic               cand_v, cur_v, take, ret;
  logic [SW-1:0]      push_i, pop_i;
  assign rise   = bus.exp_src & ~prev;
  assign push_i = SW'(depth);
  assign pop_i  = SW'(depth - DW'(1));
  always_comb begin
    cand_v = 1'b0;
    cand_i = '0;
    cur_v  = 1'b0;
    cur_i  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] & mask[i]) begin
        cand_v = 1'b1;
        cand_i = IW'(i);
      end
      if (in_service[i]) begin
        cur_v = 1'b1;
        cur_i = IW'(i);
      end
    end
  end
  assign cand_oh = NUM_SRC'(1) << cand_i;
  assign cur_oh  = NUM_SRC'(1) << cur_i;
`ifdef EXC_NESTING_EN
  assign take = cand_v & ~bus.exp_block & ~bus.is_eret & (~cur_v | (cand_i > cur_i));
`else
  // Single EPC slot: nothing preempts a handler, whatever its priority.
  assign take = cand_v & ~bus.exp_block & ~bus.is_eret & (depth == '0);
`endif
  assign ret  = bus.is_eret & (depth != '0);
  assign bus.has_exp    = take;
  assign bus.ret_valid  = ret;
  assign bus.target_pc  = take ? VEC_BASE + 32'(cand_i) * VEC_STRIDE : ret ? stk[pop_i] : 32'h0;
  assign bus.pending    = pending;
  assign bus.in_service = in_service;
  assign bus.mask       = mask;
  assign bus.depth      = depth;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '1;
      depth      <= '0;
      for (int k = 0; k < SD; k++) stk[k] <= '0;
    end else begin
      prev    <= bus.exp_src;
      pending <= (pending & ~(take ? cand_oh : '0)) | rise;
      if (bus.mask_we) mask <= bus.mask_wdata;
      if (take) begin
        stk[push_i] <= bus.pc_in;
        in_service  <= in_service | cand_oh;
        depth       <= depth + DW'(1);
      end else if (ret) begin
        in_service <= in_service & ~cur_oh;
        depth      <= depth - DW'(1);
      end
    end
  end
endmodule

// File: tb/tb_exc_ctrl_nested.sv
// tb_exc_ctrl_nested: table-driven check of exc_ctrl_nested plus nesting, held-level and reset sequences
module tb_exc_ctrl_nested;
  typedef struct {
    logic [2:0]  es;
    logic        eb, mw;
    logic [2:0]  md;
    logic [31:0] pc;
    logic        er, he, rv;
    logic [31:0] tpc;
    logic [2:0]  pend, ins, msk;
    logic [1:0]  dep;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   miscompares = 0;
  int   ntake;
  string tag;
  vec_t tv [21];
  exc_ctrl_nested_if #(.NUM_SRC(3)) bus ();
  exc_ctrl_nested #(.NUM_SRC(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [2:0] es, logic eb, logic mw, logic [2:0] md, logic [31:0] pc,
                              logic er, logic he, logic rv, logic [31:0] tpc,
                              logic [2:0] pend, logic [2:0] ins, logic [2:0] msk, logic [1:0] dep);
    vec_t v;
    v.es = es; v.eb = eb; v.mw = mw; v.md = md; v.pc = pc; v.er = er;
    v.he = he; v.rv = rv; v.tpc = tpc; v.pend = pend; v.ins = ins; v.msk = msk; v.dep = dep;
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s %s: got %h want %h", tag, n, a, e);
    end
  endtask
  task automatic apply(input string t, input vec_t v);
    @(negedge clk);
    bus.exp_src = v.es; bus.exp_block = v.eb; bus.mask_we = v.mw;
    bus.mask_wdata = v.md; bus.pc_in = v.pc; bus.is_eret = v.er;
    #1;
    tag = t;
    nvec++;
    chk("has_exp", 32'(bus.has_exp), 32'(v.he));
    chk("ret_valid", 32'(bus.ret_valid), 32'(v.rv));
    chk("target_pc", bus.target_pc, v.tpc);
    chk("pending", 32'(bus.pending), 32'(v.pend));
    chk("in_service", 32'(bus.in_service), 32'(v.ins));
    chk("mask", 32'(bus.mask), 32'(v.msk));
    chk("depth", 32'(bus.depth), 32'(v.dep));
  endtask
  initial begin
    //          es eb mw md pc          er he rv tpc         pend ins msk dep
    tv[0]  = mk(0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,     0,   0,  7,  0);
    tv[1]  = mk(2, 0, 0, 0, 32'h40,    0, 0, 0, 32'h0,     0,   0,  7,  0);
    tv[2]  = mk(2, 0, 0, 0, 32'h40,    0, 1, 0, 32'h880,   2,   0,  7,  0);
    tv[3]  = mk(0, 0, 0, 0, 32'h884,   1, 0, 1, 32'h40,    0,   2,  7,  1);
    tv[4]  = mk(0, 0, 0, 0, 32'h0,     1, 0, 0, 32'h0,     0,   0,  7,  0);
    tv[5]  = mk(0, 0, 1, 5, 32'h0,     0, 0, 0, 32'h0,     0,   0,  7,  0);
    tv[6]  = mk(2, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,     0,   0,  5,  0);
    tv[7]  = mk(2, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,     2,   0,  5,  0);
    tv[8]  = mk(0, 0, 1, 7, 32'h0,     0, 0, 0, 32'h0,     2,   0,  5,  0);
    tv[9]  = mk(0, 0, 0, 0, 32'h100,   0, 1, 0, 32'h880,   2,   0,  7,  0);
    tv[10] = mk(4, 0, 0, 0, 32'h104,   0, 0, 0, 32'h0,     0,   2,  7,  1);
    tv[11] = mk(4, 0, 0, 0, 32'h108,   1, 0, 1, 32'h100,   4,   2,  7,  1);
    tv[12] = mk(4, 0, 0, 0, 32'h10c,   0, 1, 0, 32'h900,   4,   0,  7,  0);
    tv[13] = mk(0, 0, 0, 0, 32'h0,     1, 0, 1, 32'h10c,   0,   4,  7,  1);
    tv[14] = mk(1, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,     0,   0,  7,  0);
    tv[15] = mk(0, 1, 0, 0, 32'h0,     0, 0, 0, 32'h0,     1,   0,  7,  0);
    tv[16] = mk(1, 0, 0, 0, 32'h200,   0, 1, 0, 32'h800,   1,   0,  7,  0);
    tv[17] = mk(1, 0, 0, 0, 32'h0,     1, 0, 1, 32'h200,   1,   1,  7,  1);
    tv[18] = mk(1, 0, 0, 0, 32'h300,   0, 1, 0, 32'h800,   1,   0,  7,  0);
    tv[19] = mk(1, 0, 0, 0, 32'h0,     1, 0, 1, 32'h300,   0,   1,  7,  1);
    tv[20] = mk(0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,     0,   0,  7,  0);
    bus.exp_src = '0; bus.exp_block = 1'b0; bus.mask_we = 1'b0;
    bus.mask_wdata = '0; bus.pc_in = '0; bus.is_eret = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) apply($sformatf("tv%0d", i), tv[i]);
    apply("nest0", mk(2, 0, 0, 0, 32'h40,  0, 0, 0, 32'h0,   0, 0, 7, 0));
    apply("nest1", mk(2, 0, 0, 0, 32'h40,  0, 1, 0, 32'h880, 2, 0, 7, 0));
    apply("nest2", mk(6, 0, 0, 0, 32'h884, 0, 0, 0, 32'h0,   0, 2, 7, 1));
`ifdef EXC_NESTING_EN
    apply("nest3", mk(6, 0, 0, 0, 32'h884, 0, 1, 0, 32'h900, 4, 2, 7, 1));
    apply("nest4", mk(7, 0, 0, 0, 32'h904, 0, 0, 0, 32'h0,   0, 6, 7, 2));
    apply("nest5", mk(7, 0, 0, 0, 32'h908, 0, 0, 0, 32'h0,   1, 6, 7, 2));
    apply("nest6", mk(7, 0, 0, 0, 32'h0,   1, 0, 1, 32'h884, 1, 6, 7, 2));
    apply("nest7", mk(7, 0, 0, 0, 32'h0,   1, 0, 1, 32'h40,  1, 2, 7, 1));
    apply("nest8", mk(7, 0, 0, 0, 32'h500, 0, 1, 0, 32'h800, 1, 0, 7, 0));
    apply("nest9", mk(7, 0, 0, 0, 32'h0,   1, 0, 1, 32'h500, 0, 1, 7, 1));
`else
    apply("hold3", mk(6, 0, 0, 0, 32'h884, 0, 0, 0, 32'h0,   4, 2, 7, 1));
    apply("hold4", mk(6, 0, 0, 0, 32'h0,   1, 0, 1, 32'h40,  4, 2, 7, 1));
    apply("hold5", mk(6, 0, 0, 0, 32'h600, 0, 1, 0, 32'h900, 4, 0, 7, 0));
    apply("hold6", mk(6, 0, 0, 0, 32'h0,   1, 0, 1, 32'h600, 0, 4, 7, 1));
`endif
    apply("idle", mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 7, 0));
    ntake = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.exp_src = 3'b001; bus.is_eret = 1'b0; bus.pc_in = 32'h700;
      #1;
      if (bus.has_exp) ntake++;
    end
    tag = "level_hold";
    nvec++;
    chk("take_count", 32'(ntake), 32'd1);
    @(negedge clk);
    bus.mask_we = 1'b1; bus.mask_wdata = 3'b000;
    @(negedge clk);
    bus.mask_we = 1'b0;
    #1;
    tag = "pre_reset";
    nvec++;
    chk("depth", 32'(bus.depth), 32'd1);
    chk("mask", 32'(bus.mask), 32'd0);
    #1;
    bus.is_eret = 1'b1;
    rst = 1'b1;
    #1;
    tag = "async_reset";
    nvec++;
    chk("depth", 32'(bus.depth), 32'd0);
    chk("mask", 32'(bus.mask), 32'd7);
    chk("in_service", 32'(bus.in_service), 32'd0);
    chk("has_exp", 32'(bus.has_exp), 32'd0);
    chk("ret_valid", 32'(bus.ret_valid), 32'd0);
    chk("target_pc", bus.target_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.is_eret = 1'b0;
    apply("post_reset_rise", mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 32'h800, 1, 0, 7, 0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end
endmodule
